// File: rtl/norm_pipe.sv
// Two-stage normalisation pipeline between the add/mul datapath and rounding.
// S1 resolves sign and leading-zero count; S2 shifts, adjusts exponent and folds the tail into sticky.
module norm_pipe #(
    parameter int FRAC_W = 75,
    parameter int OUT_W  = 27,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              s_tmp,
    input  logic              final_m,
    input  logic              frac_inter_h_s,
    input  logic [EXP_W-1:0]  exp_tmp,
    input  logic [FRAC_W-1:0] frac_inter,
    input  logic              flush_denorm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              s_final,
    output logic [EXP_W-1:0]  exp_norm,
    output logic [OUT_W-1:0]  frac_inter_norm,
    output logic              zero_m,
    output logic              denorm_m
);
    localparam int LZ_W = $clog2(FRAC_W + 1);
    localparam int KEEP = OUT_W - 1;

    logic              s2_adv;
    logic              s1_adv;
    logic              s1_valid;
    logic              s1_sign;
    logic [LZ_W-1:0]   s1_lz;
    logic [EXP_W-1:0]  s1_exp;
    logic [FRAC_W-1:0] s1_frac;
    logic              s1_flush;
    logic [LZ_W-1:0]   lz_c;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Highest set bit wins because it is visited last.
    always_comb begin
        lz_c = LZ_W'(FRAC_W);
        for (int i = 0; i < FRAC_W; i++) begin
            if (frac_inter[i]) lz_c = LZ_W'(FRAC_W - 1 - i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_lz    <= '0;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_flush <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= final_m ? s_tmp : (s_tmp ^ frac_inter_h_s);
                s1_lz    <= lz_c;
                s1_exp   <= exp_tmp;
                s1_frac  <= frac_inter;
                s1_flush <= flush_denorm;
            end
        end
    end

    logic [FRAC_W-1:0] t1;
    logic [FRAC_W-1:0] t2;
    logic [EXP_W:0]    e;
    logic [EXP_W:0]    rs;
    logic [LZ_W-1:0]   rs_sat;
    logic              is_zero;
    logic              is_den;
    logic              lost;
    logic              sticky;
    logic [EXP_W-1:0]  nxt_exp;
    logic [OUT_W-1:0]  nxt_frac;
    logic              nxt_zero;
    logic              nxt_den;

    // e is one bit wider than the exponent so exp_tmp - lz cannot wrap.
    always_comb begin
        t1      = s1_frac << s1_lz;
        e       = {s1_exp[EXP_W-1], s1_exp} - (EXP_W+1)'(s1_lz);
        rs      = (EXP_W+1)'(1) - e;
        rs_sat  = (rs >= (EXP_W+1)'(FRAC_W)) ? LZ_W'(FRAC_W) : rs[LZ_W-1:0];
        is_zero = (s1_frac == '0);
        is_den  = !is_zero && (e[EXP_W] || (e == '0));
        t2      = t1;
        lost    = 1'b0;
        if (is_den) begin
            t2   = t1 >> rs_sat;
            lost = |(t1 & ~({FRAC_W{1'b1}} << rs_sat));
        end
        sticky   = (|t2[FRAC_W-OUT_W:0]) | lost;
        nxt_frac = {t2[FRAC_W-1 -: KEEP], sticky};
        nxt_exp  = e[EXP_W-1:0];
        nxt_zero = 1'b0;
        nxt_den  = 1'b0;
        if (is_zero) begin
            nxt_exp  = '0;
            nxt_frac = '0;
            nxt_zero = 1'b1;
        end else if (is_den) begin
            nxt_exp = '0;
            if (s1_flush) begin
                nxt_frac = '0;
                nxt_zero = 1'b1;
            end else begin
                nxt_den = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            s_final         <= 1'b0;
            exp_norm        <= '0;
            frac_inter_norm <= '0;
            zero_m          <= 1'b0;
            denorm_m        <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s_final         <= s1_sign;
                exp_norm        <= nxt_exp;
                frac_inter_norm <= nxt_frac;
                zero_m          <= nxt_zero;
                denorm_m        <= nxt_den;
            end
        end
    end

endmodule

// File: tb/tb_norm_pipe.sv
// Bench for norm_pipe: vector table fed through a scoreboard queue,
// plus hand sequences for latency, backpressure and mid-stream reset.
module tb_norm_pipe;
    localparam int FW = 75;
    localparam int OW = 27;
    localparam int EW = 10;
    localparam int NV = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic          s_tmp;
    logic          final_m;
    logic          frac_inter_h_s;
    logic [EW-1:0] exp_tmp;
    logic [FW-1:0] frac_inter;
    logic          flush_denorm;
    logic          out_valid;
    logic          out_ready;
    logic          s_final;
    logic [EW-1:0] exp_norm;
    logic [OW-1:0] frac_inter_norm;
    logic          zero_m;
    logic          denorm_m;

    always #5 clk = ~clk;

    norm_pipe #(.FRAC_W(FW), .OUT_W(OW), .EXP_W(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .s_tmp(s_tmp), .final_m(final_m), .frac_inter_h_s(frac_inter_h_s),
        .exp_tmp(exp_tmp), .frac_inter(frac_inter), .flush_denorm(flush_denorm),
        .out_valid(out_valid), .out_ready(out_ready),
        .s_final(s_final), .exp_norm(exp_norm), .frac_inter_norm(frac_inter_norm),
        .zero_m(zero_m), .denorm_m(denorm_m)
    );

    typedef struct packed {
        logic          s;
        logic [EW-1:0] e;
        logic [OW-1:0] f;
        logic          z;
        logic          d;
    } res_t;

    typedef struct packed {
        logic [FW-1:0] frac;
        logic [EW-1:0] ex;
        logic          st;
        logic          fm;
        logic          hs;
        logic          fl;
        res_t          er;
    } vec_t;

    vec_t vecs [NV];
    res_t exp_q [$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [FW-1:0] fb(input int n);
        logic [FW-1:0] one;
        one = 1;
        return one << n;
    endfunction

    function automatic logic [OW-1:0] ob(input int n);
        logic [OW-1:0] one;
        one = 1;
        return one << n;
    endfunction

    function automatic vec_t mk(input logic [FW-1:0] frac, input logic [EW-1:0] ex,
                                input logic st, input logic fm, input logic hs, input logic fl,
                                input logic rs, input logic [EW-1:0] re, input logic [OW-1:0] rf,
                                input logic rz, input logic rd);
        vec_t v;
        v.frac = frac; v.ex = ex; v.st = st; v.fm = fm; v.hs = hs; v.fl = fl;
        v.er.s = rs; v.er.e = re; v.er.f = rf; v.er.z = rz; v.er.d = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        frac_inter     = v.frac;
        exp_tmp        = v.ex;
        s_tmp          = v.st;
        final_m        = v.fm;
        frac_inter_h_s = v.hs;
        flush_denorm   = v.fl;
    endtask

    // Output monitor: scoreboard pop on transfer, stability check while stalled.
    res_t got_r, prev_r, want_r;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        got_r = {s_final, exp_norm, frac_inter_norm, zero_m, denorm_m};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid && !out_ready && prev_stall) begin
                checks++;
                if (got_r !== prev_r) begin
                    failures++;
                    $display("FAIL stall_stable got=%h want=%h", got_r, prev_r);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_r = got_r;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=%h want=none", got_r);
                end else begin
                    want_r = exp_q.pop_front();
                    if (got_r !== want_r) begin
                        failures++;
                        $display("FAIL result got s=%0b e=%0d f=%h z=%0b d=%0b want s=%0b e=%0d f=%h z=%0b d=%0b",
                                 got_r.s, got_r.e, got_r.f, got_r.z, got_r.d,
                                 want_r.s, want_r.e, want_r.f, want_r.z, want_r.d);
                    end
                end
            end
        end
    end

    // Streams n table entries; out_ready stays low for the first `hold` cycles.
    task automatic run_stream(input int start, input int n, input int hold, output int cyc);
        int   sent;
        logic acc;
        sent = 0;
        cyc = 0;
        while ((sent < n || exp_q.size() > 0) && cyc < 200) begin
            out_ready = (cyc >= hold);
            in_valid  = (sent < n);
            if (sent < n) drive(vecs[start + sent]);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (hold >= 3 && cyc == hold - 1) begin
                check("bp_accepts", 64'(sent), 64'd2);
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(vecs[start + sent].er);
                sent++;
            end
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 200) check("stream_timeout", 64'(cyc), 64'd0);
    endtask

    initial begin
        int cyc;
        vecs[0]  = mk(fb(74), 10'd100, 1, 1, 0, 0,  1, 10'd100, ob(26), 0, 0);
        vecs[1]  = mk(fb(70) | fb(0), 10'd100, 1, 0, 1, 0,  0, 10'd96, ob(26) | ob(0), 0, 0);
        vecs[2]  = mk(75'd3, 10'd5, 0, 1, 0, 0,  0, 10'd0, ob(0), 0, 1);
        vecs[3]  = mk(75'd3, 10'd5, 0, 1, 0, 1,  0, 10'd0, '0, 1, 0);
        vecs[4]  = mk('0, 10'd37, 1, 1, 0, 0,  1, 10'd0, '0, 1, 0);
        vecs[5]  = mk(fb(0), 10'd200, 0, 0, 0, 0,  0, 10'd126, ob(26), 0, 0);
        vecs[6]  = mk(fb(70), 10'd5, 1, 0, 0, 0,  1, 10'd1, ob(26), 0, 0);
        vecs[7]  = mk(fb(70), 10'd4, 0, 0, 1, 0,  1, 10'd0, ob(25), 0, 1);
        vecs[8]  = mk(fb(74) | fb(48), 10'd50, 0, 1, 0, 0,  0, 10'd50, ob(26) | ob(0), 0, 0);
        vecs[9]  = mk(fb(74) | fb(49), 10'd50, 0, 1, 0, 0,  0, 10'd50, ob(26) | ob(1), 0, 0);
        vecs[10] = mk(fb(74), 10'h3FD, 0, 1, 0, 0,  0, 10'd0, ob(22), 0, 1);
        vecs[11] = mk(fb(74) | fb(0), 10'h39C, 0, 0, 1, 0,  1, 10'd0, ob(0), 0, 1);
        vecs[12] = mk(fb(74) | fb(0), 10'h3FF, 0, 1, 0, 0,  0, 10'd0, ob(24) | ob(0), 0, 1);
        vecs[13] = mk(fb(74), 10'd511, 0, 1, 0, 0,  0, 10'd511, ob(26), 0, 0);
        vecs[14] = mk(fb(74), 10'h200, 1, 1, 0, 1,  1, 10'd0, '0, 1, 0);

        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(vecs[0]);

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({s_final, exp_norm, frac_inter_norm, zero_m, denorm_m}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        run_stream(0, NV, 0, cyc);
        check("throughput_cycles", 64'(cyc), 64'(NV + 2));

        // Latency: accept edge, then out_valid after the second edge.
        out_ready = 1'b1;
        drive(vecs[1]);
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(vecs[1].er);
        #1;
        in_valid = 1'b0;
        check("lat_edge1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        check("lat_drained", 64'(out_valid), 64'd0);

        run_stream(1, 5, 4, cyc);

        // Mid-stream reset with two results in flight.
        out_ready = 1'b0;
        drive(vecs[5]);
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(vecs[5].er);
        #1;
        drive(vecs[6]);
        @(posedge clk);
        exp_q.push_back(vecs[6].er);
        #1;
        in_valid = 1'b0;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_outputs", 64'({s_final, exp_norm, frac_inter_norm, zero_m, denorm_m}), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rerst_in_ready", 64'(in_ready), 64'd1);
        check("rerst_out_valid", 64'(out_valid), 64'd0);
        run_stream(2, 1, 0, cyc);
        check("rerst_latency", 64'(cyc), 64'd3);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/norm_pipe.md
Name: norm_pipe

Overview:
- Parametrised, pipelined successor of the combinational normalization stage. Sits between the adder/multiplier datapath and the rounding stage.
- Computes the final sign and counts leading zeros on a wide intermediate fraction. Left-normalises the fraction, adjusts the exponent, handles denormal/zero results, and compresses the tail into a sticky bit.
- Adds a valid/ready handshake with backpressure, 2-cycle latency, and an optional denormal flush-to-zero mode.

Parameters:
FRAC_W, 75, width of intermediate fraction input
OUT_W, 27, width of normalized fraction output (OUT_W-1 kept bits + 1 sticky); OUT_W < FRAC_W
EXP_W, 10, exponent width, two's-complement signed

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept input this cycle
s_tmp  input  1  tentative sign
final_m  input  1  1: s_tmp is final; 0: sign = s_tmp ^ frac_inter_h_s
frac_inter_h_s  input  1  sign-correction bit from datapath
exp_tmp  input  EXP_W  signed tentative exponent
frac_inter  input  FRAC_W  unnormalized magnitude
flush_denorm  input  1  1: denormal results flush to zero; sampled with in_valid
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
s_final  output  1  final sign
exp_norm  output  EXP_W  adjusted exponent
frac_inter_norm  output  OUT_W  normalized fraction, LSB = sticky
zero_m  output  1  result is zero
denorm_m  output  1  result is denormal (not flushed)

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids = 0, out_valid = 0, all output data registers = 0. in_ready goes high on the first cycle after release.
- Pipeline, S1 (input capture):
  - Registers s_final = final_m ? s_tmp : s_tmp ^ frac_inter_h_s.
  - Registers lz = leading-zero count of frac_inter (lz = FRAC_W when frac_inter == 0).
  - Registers exp_tmp, frac_inter and flush_denorm.
- Pipeline, S2 (output register):
  - Shift, exponent, denorm/zero and sticky logic feed the outputs.
- Latency: exactly 2 clk edges from input accept to out_valid under no backpressure. Throughput 1 per cycle.
- Handshake:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - Input transfers when in_valid & in_ready. Output transfers when out_valid & out_ready.
  - Stalled stages hold data unchanged. No drops, no duplicates, order preserved.
- Output data is stable while out_valid = 1 and out_ready = 0.
- in_ready is combinational from out_ready. No combinational path from in_valid to out_valid.
- Arithmetic (S2, exp signed, width EXP_W+1 internally to avoid overflow):
  - t1 = frac << lz.
  - e = exp_tmp - lz.
- Zero case: frac == 0 -> zero_m = 1, denorm_m = 0, exp_norm = 0, frac_inter_norm = 0. Sign passes through.
- Denormal case: frac != 0 and e <= 0.
  - rs = 1 - e, saturated at FRAC_W. t2 = t1 >> rs, with shifted-out bits ORed into sticky. exp_norm = 0.
  - If flush_denorm = 0: denorm_m = 1, zero_m = 0.
  - If flush_denorm = 1: frac_inter_norm = 0, zero_m = 1, denorm_m = 0.
- Normal case: t2 = t1, exp_norm = e[EXP_W-1:0], zero_m = 0, denorm_m = 0.
- Output fraction: frac_inter_norm = {t2[FRAC_W-1 : FRAC_W-OUT_W+1], sticky}.
  - sticky = |t2[FRAC_W-OUT_W : 0] OR any bit lost in the right shift.
- Exponent overflow (e > 2^(EXP_W-1)-1) is not detected here. The value is truncated and flagged by the rounding stage.
- Reset mid-operation discards all in-flight results. No output handshake completes for them.

Test Plan:
- Normal, no shift: frac = 1<<74, exp = 100, final_m = 1, s_tmp = 1 -> after 2 cycles exp_norm = 100, frac_inter_norm = 1<<26, s_final = 1, zero_m = 0, denorm_m = 0.
- Shift plus sticky: frac = (1<<70)|1, exp = 100, final_m = 0, s_tmp = 1, h_s = 1 -> exp_norm = 96, frac_inter_norm = (1<<26)|1, s_final = 0.
- Denormal: frac = 3, exp = 5, flush = 0 -> lz = 73, e = -68, rs = 69; frac_inter_norm = 1 (sticky only), exp_norm = 0, denorm_m = 1. Same input with flush = 1 -> zero_m = 1, frac_inter_norm = 0, denorm_m = 0.
- Zero: frac = 0, exp = 37 -> zero_m = 1, exp_norm = 0, frac_inter_norm = 0.
- Backpressure: stream 5 back-to-back inputs while out_ready = 0 for 4 cycles -> in_ready drops after 2 accepts. After out_ready = 1, all 5 results emerge in order, data stable while stalled.
- Reset mid-stream: rst_n low with 2 results in flight -> out_valid = 0 and outputs 0 immediately. After release the next input yields a correct result after 2 cycles.
